sync_filter: RTL
================

SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: number of independent channels.
REQ-002 The block SHALL have parameter STAGES, default 2: synchronizer flop depth per channel, legal range 2..4.
REQ-003 The block SHALL have parameter FILTER_LEN, default 1: consecutive stable cycles required before the output follows; legal range 1..65535; 1 means no filtering.
REQ-004 The block SHALL have parameter RESET_VAL, default all zeros, WIDTH bits: per-channel reset level.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; the block uses one clock, and all flops are on posedge clk.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port i, input, WIDTH bits: asynchronous or foreign-domain inputs.
REQ-008 The block SHALL have port o, output, WIDTH bits: synchronized, filtered level.
REQ-009 The block SHALL have port rise, output, WIDTH bits: one-cycle pulse when o goes 0->1.
REQ-010 The block SHALL have port fall, output, WIDTH bits: one-cycle pulse when o goes 1->0.

Function
REQ-011 Each channel SHALL pass i[n] through a STAGES-deep flop chain; y[n] is the last flop's output; no logic SHALL sit between chain flops.
REQ-012 Each channel SHALL hold a counter c of width clog2(FILTER_LEN+1), saturating logic not needed since c never exceeds FILTER_LEN-1.
REQ-013 Per cycle with y==o, the block SHALL set c<=0 and hold o.
REQ-014 Per cycle with y!=o and c==FILTER_LEN-1, the block SHALL set o<=y and c<=0.
REQ-015 Per cycle with y!=o and c<FILTER_LEN-1, the block SHALL set c<=c+1 and hold o.
REQ-016 A level change on i held stable SHALL appear on o exactly STAGES+FILTER_LEN clock edges after the first edge that samples it.
REQ-017 A pulse on y shorter than FILTER_LEN cycles SHALL NOT change o, and its counter SHALL return to 0 on the first cycle y==o again.
REQ-018 rise[n]/fall[n] SHALL be registered and SHALL be high in the same cycle o[n] first shows its new value, for exactly one cycle.
REQ-019 rise and fall SHALL never be high together on one channel.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-021 The counter SHALL NOT wrap; at FILTER_LEN=65535 the counter SHALL be 16 bits and reach 65534 before update.

Reset
REQ-022 While rst=1 at a clock edge, all sync flops and o SHALL load RESET_VAL, c SHALL load 0, and rise/fall SHALL load 0.
REQ-023 Reset asserted mid-count SHALL discard the pending transition; no pulse SHALL appear in the cycle after rst falls.
REQ-024 After reset, if i equals RESET_VAL, no rise/fall SHALL ever be emitted until i changes.
REQ-025 After reset, if i differs from RESET_VAL, the block SHALL emit one normal edge pulse after STAGES+FILTER_LEN edges following rst deassertion.

Structure
REQ-026 The block SHALL use no shared package; counter width SHALL be a local parameter via a clog2 constant function in the module.
REQ-027 The block SHALL use one sub-module, sync_filter_chan (one channel: chain, counter, o, rise, fall), instantiated WIDTH times via generate.
REQ-028 The sync chain flops SHALL carry the codebase's ASYNC_REG/synchronizer attribute.

Verification
REQ-029 The bench SHALL cover: WIDTH=1, STAGES=2, FILTER_LEN=1, step i 0->1 -> o=1 and rise=1 at edge 3 after sampling, rise low at edge 4.
REQ-030 The bench SHALL cover: STAGES=3, FILTER_LEN=4, i high 3 cycles then low -> o stays 0, no pulse; i high 4 cycles -> o=1 at edge 7, rise one cycle.
REQ-031 The bench SHALL cover: WIDTH=4, RESET_VAL=4'b1010, i=4'b1010 after reset -> o=4'b1010, no pulses for 100 cycles; then i=4'b0101 -> rise=4'b0101 and fall=4'b1010 in the same cycle.
REQ-032 The bench SHALL cover: FILTER_LEN=8, i toggled, rst pulsed at count 5 -> o=RESET_VAL, c=0, no pulse in the following 2 cycles; re-stable i yields transition 2+8 edges later.
REQ-033 The bench SHALL cover: FILTER_LEN=65535, i held changed -> o updates at edge 65537, with no wrap or early update.
REQ-034 The bench SHALL cover: random i with 1-10 cycle glitches, FILTER_LEN=5, 10k cycles -> scoreboard model match, rise/fall never both high, and every o change paired with exactly one pulse.

Source files
------------

// File: rtl/sync_filter_chan.sv
// sync_filter_chan: one channel of the synchronizer/filter.
//   A STAGES-deep synchronizer chain brings d into the clk domain. A run
//   counter then requires the synchronized level (y) to differ from o for
//   FILTER_LEN consecutive cycles before o follows it. rise/fall are
//   registered and line up with the cycle in which o takes its new value.
// Ports:
//   clk   - clock, all flops on posedge
//   rst   - synchronous active-high reset
//   d     - asynchronous / foreign-domain input bit
//   o     - synchronized, filtered level
//   rise  - one-cycle pulse when o goes 0->1
//   fall  - one-cycle pulse when o goes 1->0
module sync_filter_chan #(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 1,
    parameter int   CNT_W      = 1,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic o,
    output logic rise,
    output logic fall
);

    // Count value at which the pending level is accepted. The counter never
    // exceeds this, so it cannot wrap even when it uses its full width.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_reg;

    logic [CNT_W-1:0] cnt_reg;
    logic             o_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic             y;

    // Pure flop-to-flop chain: nothing is allowed between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= {STAGES{RESET_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign y = sync_reg[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            o_reg    <= RESET_VAL;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            if (y == o_reg) begin
                // Any return to the current level abandons a pending change.
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                o_reg    <= y;
                cnt_reg  <= '0;
                rise_reg <= y;
                fall_reg <= ~y;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign o    = o_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/sync_filter.sv
// sync_filter: WIDTH independent synchronizer + glitch-filter channels.
//   Each channel is a sync_filter_chan; channels share only clk and rst.
//   A level change held stable on i[n] shows up on o[n] STAGES+FILTER_LEN
//   edges after the first edge that samples it, together with a one-cycle
//   rise[n] or fall[n] pulse.
// Parameters:
//   WIDTH      - number of channels
//   STAGES     - synchronizer depth, 2..4
//   FILTER_LEN - stable cycles required before o follows, 1..65535 (1 = none)
//   RESET_VAL  - per-channel reset level
// Ports:
//   clk        - clock, all flops on posedge
//   rst        - synchronous active-high reset
//   i          - asynchronous / foreign-domain inputs
//   o          - synchronized, filtered levels
//   rise/fall  - one-cycle edge pulses per channel
module sync_filter #(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Ceiling log2, evaluated at elaboration for the counter width.
    function automatic int clog2_f(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Counter must hold 0..FILTER_LEN-1; FILTER_LEN+1 keeps FILTER_LEN=1
    // at a legal 1-bit width and gives 16 bits at FILTER_LEN=65535.
    localparam int CNT_W = clog2_f(FILTER_LEN + 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            sync_filter_chan #(
                .STAGES     (STAGES),
                .FILTER_LEN (FILTER_LEN),
                .CNT_W      (CNT_W),
                .RESET_VAL  (RESET_VAL[gi])
            ) u_chan (
                .clk  (clk),
                .rst  (rst),
                .d    (i[gi]),
                .o    (o[gi]),
                .rise (rise[gi]),
                .fall (fall[gi])
            );
        end
    endgenerate

endmodule
